// File: rtl/wallace_sched_pkg.sv
// Shared types and widths for the two-requester multiplier scheduler.
package wallace_sched_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wallace_sched_rr_arb2.sv
// Two-way round-robin arbiter; the most recent winner loses the next tie.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic en_i,
  input  logic upd_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // 1 means requester 1 won last, so requester 0 takes the first tie after reset
  logic last_q, last_d;

  always_comb begin
    gnt0_o = en_i & req0_i & (~req1_i | last_q);
    gnt1_o = en_i & req1_i & (~req0_i | ~last_q);
    last_d = last_q;
    if (upd_i) begin
      last_d = gnt1_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/wallace_sched.sv
// Shares one external combinational 32x32 multiplier between two requesters,
// holding operands for MUL_LAT cycles before capturing the 64-bit product.
module wallace_sched
  import wallace_sched_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OP_W-1:0]     req0_a,
  input  logic [OP_W-1:0]     req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OP_W-1:0]     req1_a,
  input  logic [OP_W-1:0]     req1_b,
  output logic [OP_W-1:0]     mul_a,
  output logic [OP_W-1:0]     mul_b,
  input  logic [PROD_W-1:0]   mul_p,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PROD_W-1:0]   res_p,
  output logic                res_src,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OP_W-1:0]     mul_a_q, mul_a_d;
  logic [OP_W-1:0]     mul_b_q, mul_b_d;
  logic [PROD_W-1:0]   res_p_q, res_p_d;
  logic                res_src_q, res_src_d;
  logic                res_valid_q, res_valid_d;

  logic                arb_en;
  logic                gnt0, gnt1;
  logic                accept;

  assign arb_en = (state_q == IDLE);
  assign accept = gnt0 | gnt1;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req0_i (req0_valid),
    .req1_i (req1_valid),
    .en_i   (arb_en),
    .upd_i  (accept),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_p_d     = res_p_q;
    res_src_d   = res_src_q;
    res_valid_d = res_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = MUL;
          mul_a_d   = gnt1 ? req1_a : req0_a;
          mul_b_d   = gnt1 ? req1_b : req0_b;
          res_src_d = gnt1;
          cnt_d     = CNT_W'(MUL_LAT - 1);
        end
      end
      // Operands stay frozen here; the product is only trusted once the count expires
      MUL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          res_p_d     = mul_p;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_p_q     <= '0;
      res_src_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_p_q     <= res_p_d;
      res_src_q   <= res_src_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign res_p      = res_p_q;
  assign res_src    = res_src_q;
  assign res_valid  = res_valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/wallace_sched.md
Name: wallace_sched

Overview:
- Round-robin scheduler that shares one 32x32 wallace tree multiplier (64-bit product) between two requesters.
- Sits between two multiply clients (e.g. mantissa multiply of two FP pipes) and a single multiplier instance, which it drives through registered operands.
- The multiplier is purely combinational and deep, so the block holds operands stable for a configurable number of cycles before sampling the product (multicycle path).
- Results return on a single valid/ready output port, tagged with the source requester.

Parameters:
- MUL_LAT, 2: cycles operands are held on mul_a/mul_b before mul_p is sampled. Legal range 1..15.
- CNT_W, 4: width of the latency counter. Must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a  in  32  requester 0 operand a
- req0_b  in  32  requester 0 operand b
- req1_valid  in  1  requester 1 has operands
- req1_ready  out  1  requester 1 operands accepted this cycle
- req1_a  in  32  requester 1 operand a
- req1_b  in  32  requester 1 operand b
- mul_a  out  32  registered operand a to the multiplier
- mul_b  out  32  registered operand b to the multiplier
- mul_p  in  64  product from the multiplier
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_p  out  64  registered product
- res_src  out  1  source requester of res_p (0 or 1)
- busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, MUL, DONE.
- Reset values (rst high at a clock edge):
  - state = IDLE
  - mul_a = 0, mul_b = 0
  - res_p = 0, res_src = 0, res_valid = 0
  - cnt = 0
  - last_grant = 1, so requester 0 wins the first tie
  - Reset mid-operation abandons the operation; no result is produced.
- Arbitration (combinational, IDLE only):
  - grant0 = req0_valid & (!req1_valid | last_grant==1)
  - grant1 = req1_valid & (!req0_valid | last_grant==0)
  - reqN_ready = (state==IDLE) & grantN. At most one ready is high per cycle; both are 0 outside IDLE.
  - ready may depend on valid; requesters must not make valid depend on ready.
  - A requester must hold valid/a/b stable until it sees ready.
- IDLE -> MUL on a handshake at edge T:
  - mul_a/mul_b <= granted operands
  - res_src <= granted index
  - last_grant <= granted index
  - cnt <= MUL_LAT-1
- MUL:
  - mul_a/mul_b held constant.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: res_p <= mul_p, res_valid <= 1, go to DONE. This capture edge is T+MUL_LAT.
  - res_valid is first high in the cycle after edge T+MUL_LAT.
- DONE:
  - res_valid = 1; res_p and res_src held until res_valid & res_ready at an edge.
  - On that edge: res_valid <= 0, go to IDLE.
  - mul_a/mul_b retain their last values; no clearing.
- Throughput: one operation per MUL_LAT+2 cycles with res_ready tied high (handshake, MUL_LAT cycles, DONE, IDLE).
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...
- Boundary conditions:
  - Requester valid deasserted while not granted: legal, no effect.
  - res_ready high during IDLE/MUL: ignored.
  - res_ready held low: the block stalls indefinitely in DONE, no overrun.
  - MUL_LAT=1: capture on the edge right after acceptance.
- Width rule: res_p is the full unsigned 64-bit product, no truncation or rounding.

Decomposition:
- Package wallace_sched_pkg:
  - state enum {IDLE, MUL, DONE}
  - constants OP_W=32, PROD_W=64
- Sub-module rr_arb2:
  - Inputs: clk, rst, two requests, enable, update.
  - Outputs: grants; owns last_grant.
- The multiplier is instantiated at the parent level, not inside this block.

Test Plan:
- Reset then single request: req0 a=3, b=5 at edge T (MUL_LAT=2) -> req0_ready=1 for that cycle; res_valid rises after edge T+2 with res_p=15, res_src=0; busy high from T+1 to DONE exit.
- Tie and alternation: both valid continuously, req0 a=0xFFFFFFFF b=0xFFFFFFFF, req1 a=0x10000 b=0x10000, res_ready=1 -> results in order src 0,1,0,1 with res_p=0xFFFFFFFE00000001 and 0x0000000100000000; new accept every 4 cycles.
- Backpressure: res_ready=0 for 10 cycles after res_valid -> res_p/res_src stable, both readys 0 and busy 1 throughout; completion follows the first res_ready=1 edge, then next accept one cycle later.
- Operand stability: change req1_a/b after acceptance -> mul_a/mul_b unchanged through MUL; result matches the accepted operands (7*9=63).
- Reset mid-operation: rst high during MUL -> next cycle state IDLE, res_valid=0, mul_a=0, no stale result emitted; first request after reset goes to requester 0 on a tie.
- MUL_LAT=1 build: a=0x80000000, b=2 -> res_p=0x100000000 valid one cycle after acceptance edge +1; throughput one per 3 cycles.
